// File: rtl/wb_buffer_pkg.sv
// Shared definitions for the write-back buffer: address-split helpers and the
// default-geometry entry record.
package wb_buffer_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE    = 32;

  function automatic int offset_width(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int tag_width(input int address_width, input int block_size);
    return address_width - $clog2(block_size);
  endfunction

  localparam int DEF_OFFSET_WIDTH = offset_width(DEF_BLOCK_SIZE);
  localparam int DEF_TAG_WIDTH    = tag_width(DEF_ADDRESS_WIDTH, DEF_BLOCK_SIZE);

  typedef struct packed {
    logic                      valid;
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_buffer_match.sv
// DEPTH-way tag compare with youngest-first priority, searching from tail-1
// backwards; only valid entries take part, so the search is correct across wrap.
module wb_buffer_match #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 27,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     valid,
  input  logic [TAG_WIDTH-1:0] tags [DEPTH],
  input  logic [PTR_WIDTH-1:0] tail,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 hit,
  output logic [PTR_WIDTH-1:0] index
);

  logic [PTR_WIDTH-1:0] probe;

  always_comb begin
    hit   = 1'b0;
    index = '0;
    probe = '0;
    for (int k = 0; k < DEPTH; k++) begin
      probe = tail - PTR_WIDTH'(k + 1);
      if (!hit && valid[probe] && (tags[probe] == tag)) begin
        hit   = 1'b1;
        index = probe;
      end
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// Posted-write FIFO between the cache write-back stage and main memory, with
// same-block coalescing and a youngest-wins read-forwarding lookup.
module write_back_buffer
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_ready_to_send,
  input  logic [ADDRESS_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     wb_ack,
  output logic                     mem_wr_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_wr_address,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  input  logic                     mem_wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] lookup_address,
  output logic                     lookup_hit,
  output logic [DATA_WIDTH-1:0]    lookup_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int OFFSET_WIDTH = offset_width(BLOCK_SIZE);
  localparam int TAG_WIDTH    = tag_width(ADDRESS_WIDTH, BLOCK_SIZE);
  localparam int PTR_WIDTH    = $clog2(DEPTH);
  localparam int COUNT_WIDTH  = PTR_WIDTH + 1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t               entries [DEPTH];
  logic [DEPTH-1:0]     entry_valid;
  logic [TAG_WIDTH-1:0] entry_tags [DEPTH];
  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;

  logic [TAG_WIDTH-1:0] wb_tag;
  logic [TAG_WIDTH-1:0] lookup_tag;
  logic                 unused_offsets;

  logic                 coalesce_hit;
  logic [PTR_WIDTH-1:0] coalesce_index;
  logic                 snoop_hit;
  logic [PTR_WIDTH-1:0] snoop_index;

  logic accept_req;
  logic do_coalesce;
  logic do_push;
  logic do_pop;

  // Offset bits only select a byte inside the block; matching is per block.
  assign wb_tag         = wb_address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
  assign lookup_tag     = lookup_address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
  assign unused_offsets = ^{wb_address[OFFSET_WIDTH-1:0], lookup_address[OFFSET_WIDTH-1:0]};

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign entry_valid[i] = entries[i].valid;
    assign entry_tags[i]  = entries[i].tag;
  end

  wb_buffer_match #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) u_coalesce_match (
    .valid (entry_valid),
    .tags  (entry_tags),
    .tail  (tail),
    .tag   (wb_tag),
    .hit   (coalesce_hit),
    .index (coalesce_index)
  );

  wb_buffer_match #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) u_lookup_match (
    .valid (entry_valid),
    .tags  (entry_tags),
    .tail  (tail),
    .tag   (lookup_tag),
    .hit   (snoop_hit),
    .index (snoop_index)
  );

  assign full         = (count == COUNT_WIDTH'(DEPTH));
  assign empty        = (count == '0);
  assign mem_wr_valid = !empty;

  // The head is always on the memory port while non-empty, so it is never
  // a coalesce target; a same-block write then gets a fresh entry instead.
  assign accept_req  = wb_ready_to_send && !wb_ack;
  assign do_coalesce = accept_req && coalesce_hit && (coalesce_index != head);
  assign do_push     = accept_req && !do_coalesce && !full;
  assign do_pop      = mem_wr_valid && mem_wr_ready;

  assign mem_wr_address = {entries[head].tag, {OFFSET_WIDTH{1'b0}}};
  assign mem_wr_data    = entries[head].data;
  assign lookup_hit     = snoop_hit;
  assign lookup_data    = snoop_hit ? entries[snoop_index].data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wb_ack <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      wb_ack <= do_push || do_coalesce;
      count  <= count + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_WIDTH'(1);
      end
      if (do_push) begin
        entries[tail] <= '{valid: 1'b1, tag: wb_tag, data: wb_data};
        tail          <= tail + PTR_WIDTH'(1);
      end
      if (do_coalesce) begin
        entries[coalesce_index].data <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for write_back_buffer: a per-cycle vector table, a drain-order
// scoreboard and a hand-written reset sequence.
module tb_write_back_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_ready_to_send = 1'b0;
  logic [31:0] wb_address = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ack;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_address;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready = 1'b0;
  logic [31:0] lookup_address = 32'h0000_8000;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic [31:0] lk;
    logic        ack;
    logic        mv;
    logic [31:0] maddr;
    logic [31:0] mdata;
    int          cnt;
    logic        hit;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] L = 32'h0000_8000;

  write_back_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .wb_ready_to_send (wb_ready_to_send),
    .wb_address       (wb_address),
    .wb_data          (wb_data),
    .wb_ack           (wb_ack),
    .mem_wr_valid     (mem_wr_valid),
    .mem_wr_address   (mem_wr_address),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_ready     (mem_wr_ready),
    .lookup_address   (lookup_address),
    .lookup_hit       (lookup_hit),
    .lookup_data      (lookup_data),
    .full             (full),
    .empty            (empty),
    .count            (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic [31:0] addr, input logic [31:0] data,
                     input logic ready, input logic [31:0] lk, input logic ack,
                     input logic mv, input logic [31:0] maddr, input logic [31:0] mdata,
                     input int cnt, input logic hit, input logic [31:0] ld);
    vec_t v;
    v.req = req; v.addr = addr; v.data = data; v.ready = ready; v.lk = lk;
    v.ack = ack; v.mv = mv; v.maddr = maddr; v.mdata = mdata; v.cnt = cnt;
    v.hit = hit; v.ld = ld;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drain scoreboard: every accepted memory write must match the expected order
  always @(negedge clk) begin
    if (!reset && mem_wr_valid && mem_wr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected actual=%0h required=none", {mem_wr_address, mem_wr_data});
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({mem_wr_address, mem_wr_data} !== e) begin
          errors++;
          $display("FAIL drain_order actual=%0h required=%0h", {mem_wr_address, mem_wr_data}, e);
        end
      end
    end
  end

  initial begin
    // single write, immediate drain, no re-accept while request held through ack
    add(1, 32'h1040, 32'hDEADBEEF, 1, L, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h1040, 32'hDEADBEEF, 1, L, 1, 1, 32'h1040, 32'hDEADBEEF, 1, 0, 0);
    add(0, 0, 0, 1, L, 0, 0, 0, 0, 0, 0, 0);
    // fill to full, blocked fifth request, no same-cycle full bypass
    add(1, 32'h100, 32'h11, 0, L, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h100, 32'h11, 0, L, 1, 1, 32'h100, 32'h11, 1, 0, 0);
    add(1, 32'h200, 32'h22, 0, L, 0, 1, 32'h100, 32'h11, 1, 0, 0);
    add(1, 32'h200, 32'h22, 0, L, 1, 1, 32'h100, 32'h11, 2, 0, 0);
    add(1, 32'h300, 32'h33, 0, L, 0, 1, 32'h100, 32'h11, 2, 0, 0);
    add(1, 32'h300, 32'h33, 0, L, 1, 1, 32'h100, 32'h11, 3, 0, 0);
    add(1, 32'h400, 32'h44, 0, L, 0, 1, 32'h100, 32'h11, 3, 0, 0);
    add(1, 32'h400, 32'h44, 0, L, 1, 1, 32'h100, 32'h11, 4, 0, 0);
    add(1, 32'h500, 32'h55, 0, L, 0, 1, 32'h100, 32'h11, 4, 0, 0);
    add(1, 32'h500, 32'h55, 0, L, 0, 1, 32'h100, 32'h11, 4, 0, 0);
    add(1, 32'h500, 32'h55, 1, L, 0, 1, 32'h100, 32'h11, 4, 0, 0);
    add(1, 32'h500, 32'h55, 0, L, 0, 1, 32'h200, 32'h22, 3, 0, 0);
    add(1, 32'h500, 32'h55, 0, L, 1, 1, 32'h200, 32'h22, 4, 0, 0);
    add(0, 0, 0, 1, L, 0, 1, 32'h200, 32'h22, 4, 0, 0);
    add(0, 0, 0, 1, L, 0, 1, 32'h300, 32'h33, 3, 0, 0);
    add(0, 0, 0, 1, L, 0, 1, 32'h400, 32'h44, 2, 0, 0);
    add(0, 0, 0, 1, L, 0, 1, 32'h500, 32'h55, 1, 0, 0);
    add(0, 0, 0, 0, L, 0, 0, 0, 0, 0, 0, 0);
    // coalesce onto a non-head entry (0x2008 lies in the 0x2000 block)
    add(1, 32'h3000, 32'hA, 0, L, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h3000, 32'hA, 0, L, 1, 1, 32'h3000, 32'hA, 1, 0, 0);
    add(1, 32'h2000, 32'h1, 0, L, 0, 1, 32'h3000, 32'hA, 1, 0, 0);
    add(1, 32'h2000, 32'h1, 0, L, 1, 1, 32'h3000, 32'hA, 2, 0, 0);
    add(1, 32'h2008, 32'h2, 0, 32'h2000, 0, 1, 32'h3000, 32'hA, 2, 1, 32'h1);
    add(1, 32'h2008, 32'h2, 0, 32'h2000, 1, 1, 32'h3000, 32'hA, 2, 1, 32'h2);
    add(0, 0, 0, 1, 32'h3000, 0, 1, 32'h3000, 32'hA, 2, 1, 32'hA);
    add(0, 0, 0, 1, 32'h2000, 0, 1, 32'h2000, 32'h2, 1, 1, 32'h2);
    add(0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
    // head protection: same block as presented head allocates a new entry
    add(1, 32'h4000, 32'h7, 0, L, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h4000, 32'h7, 0, L, 1, 1, 32'h4000, 32'h7, 1, 0, 0);
    add(1, 32'h4000, 32'h9, 0, 32'h4000, 0, 1, 32'h4000, 32'h7, 1, 1, 32'h7);
    add(1, 32'h4000, 32'h9, 0, 32'h4000, 1, 1, 32'h4000, 32'h7, 2, 1, 32'h9);
    add(0, 0, 0, 0, L, 0, 1, 32'h4000, 32'h7, 2, 0, 0);
    add(0, 0, 0, 1, 32'h4000, 0, 1, 32'h4000, 32'h7, 2, 1, 32'h9);
    add(0, 0, 0, 1, 32'h4000, 0, 1, 32'h4000, 32'h9, 1, 1, 32'h9);
    add(0, 0, 0, 0, 32'h4000, 0, 0, 0, 0, 0, 0, 0);
    // youngest match across the wrap: head = 3, tail = 1
    add(1, 32'h7000, 32'h70, 0, L, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h7000, 32'h70, 0, L, 1, 1, 32'h7000, 32'h70, 1, 0, 0);
    add(1, 32'h5000, 32'h51, 0, L, 0, 1, 32'h7000, 32'h70, 1, 0, 0);
    add(1, 32'h5000, 32'h51, 0, L, 1, 1, 32'h7000, 32'h70, 2, 0, 0);
    add(0, 0, 0, 1, L, 0, 1, 32'h7000, 32'h70, 2, 0, 0);
    add(1, 32'h5000, 32'h52, 0, 32'h5000, 0, 1, 32'h5000, 32'h51, 1, 1, 32'h51);
    add(1, 32'h5000, 32'h52, 0, 32'h5000, 1, 1, 32'h5000, 32'h51, 2, 1, 32'h52);
    add(1, 32'h9000, 32'h90, 0, 32'h5000, 0, 1, 32'h5000, 32'h51, 2, 1, 32'h52);
    add(1, 32'h9000, 32'h90, 0, 32'h5000, 1, 1, 32'h5000, 32'h51, 3, 1, 32'h52);
    add(0, 0, 0, 0, 32'h9000, 0, 1, 32'h5000, 32'h51, 3, 1, 32'h90);

    exp_q.push_back({32'h1040, 32'hDEADBEEF});
    exp_q.push_back({32'h100, 32'h11});
    exp_q.push_back({32'h200, 32'h22});
    exp_q.push_back({32'h300, 32'h33});
    exp_q.push_back({32'h400, 32'h44});
    exp_q.push_back({32'h500, 32'h55});
    exp_q.push_back({32'h3000, 32'hA});
    exp_q.push_back({32'h2000, 32'h2});
    exp_q.push_back({32'h4000, 32'h7});
    exp_q.push_back({32'h4000, 32'h9});
    exp_q.push_back({32'h7000, 32'h70});

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_ack", 64'(wb_ack), 64'd0);
    chk("reset_mem_valid", 64'(mem_wr_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_hit", 64'(lookup_hit), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      wb_ready_to_send = vecs[i].req;
      wb_address       = vecs[i].addr;
      wb_data          = vecs[i].data;
      mem_wr_ready     = vecs[i].ready;
      lookup_address   = vecs[i].lk;
      #1;
      chk($sformatf("v%0d_ack", i), 64'(wb_ack), 64'(vecs[i].ack));
      chk($sformatf("v%0d_mem_valid", i), 64'(mem_wr_valid), 64'(vecs[i].mv));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].cnt == 0));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(vecs[i].cnt == 4));
      chk($sformatf("v%0d_hit", i), 64'(lookup_hit), 64'(vecs[i].hit));
      chk($sformatf("v%0d_lookup_data", i), 64'(lookup_data), 64'(vecs[i].ld));
      if (vecs[i].mv) begin
        chk($sformatf("v%0d_mem_addr", i), 64'(mem_wr_address), 64'(vecs[i].maddr));
        chk($sformatf("v%0d_mem_data", i), 64'(mem_wr_data), 64'(vecs[i].mdata));
      end
      tick();
    end

    // reset with three entries buffered and the head on the memory port
    wb_ready_to_send = 1'b0;
    mem_wr_ready     = 1'b0;
    lookup_address   = 32'h5000;
    reset            = 1'b1;
    tick();
    chk("mid_reset_mem_valid", 64'(mem_wr_valid), 64'd0);
    chk("mid_reset_empty", 64'(empty), 64'd1);
    chk("mid_reset_count", 64'(count), 64'd0);
    chk("mid_reset_ack", 64'(wb_ack), 64'd0);
    chk("mid_reset_hit", 64'(lookup_hit), 64'd0);
    chk("mid_reset_lookup_data", 64'(lookup_data), 64'd0);

    // a fresh write after reset is accepted with one-cycle latency
    reset            = 1'b0;
    wb_ready_to_send = 1'b1;
    wb_address       = 32'hA000;
    wb_data          = 32'hA0;
    tick();
    chk("post_reset_ack", 64'(wb_ack), 64'd1);
    chk("post_reset_count", 64'(count), 64'd1);
    chk("post_reset_mem_addr", 64'(mem_wr_address), 64'h0000_A000);
    chk("post_reset_mem_data", 64'(mem_wr_data), 64'hA0);
    wb_ready_to_send = 1'b0;
    tick();

    chk("drain_remaining", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
